// File: rtl/flight_mode_sel_if.sv
// rtl/flight_mode_sel_if.sv - receiver/mixer inputs and mode-select outputs of flight_mode_sel
interface flight_mode_sel_if #(
   parameter int PWM_VALUE_BIT_WIDTH    = 8,
   parameter int REC_DATA_SEL_BIT_WIDTH = 3
);
   logic [PWM_VALUE_BIT_WIDTH-1:0]    swa_val;
   logic [PWM_VALUE_BIT_WIDTH-1:0]    swb_val;
   logic [PWM_VALUE_BIT_WIDTH-1:0]    throttle_rec_val;
   logic [PWM_VALUE_BIT_WIDTH-1:0]    curr_motor_rate;
   logic                              rx_valid;
   logic [REC_DATA_SEL_BIT_WIDTH-1:0] rec_data_sel;
   logic                              mode_changed;
   logic                              failsafe;

   modport master (
      output swa_val, swb_val, throttle_rec_val, curr_motor_rate, rx_valid,
      input  rec_data_sel, mode_changed, failsafe
   );

   modport slave (
      input  swa_val, swb_val, throttle_rec_val, curr_motor_rate, rx_valid,
      output rec_data_sel, mode_changed, failsafe
   );
endinterface

// File: rtl/flight_mode_sel.sv
// rtl/flight_mode_sel.sv - pilot-switch/failsafe flight-mode sequencer driving rec_data_sel
module flight_mode_sel #(
   parameter int PWM_VALUE_BIT_WIDTH    = 8,
   parameter int REC_DATA_SEL_BIT_WIDTH = 3,
   parameter int SW_HIGH_THRESH         = 150,
   parameter int SW_LOW_THRESH          = 100,
   parameter int DEBOUNCE_US            = 20000,
   parameter int FAILSAFE_US            = 250000,
   parameter int TAKEOFF_MAX_US         = 4000000,
   parameter int LAND_SETTLE_US         = 500000,
   parameter int ARM_THROTTLE_MAX       = 10,
   parameter int HOVER_THROTTLE_VAL     = 150,
   parameter int MOTOR_VAL_MIN          = 0,
   parameter int THROTTLE_VARIANCE      = 10,
   parameter logic [REC_DATA_SEL_BIT_WIDTH-1:0] REC_SEL_OFF           = 0,
   parameter logic [REC_DATA_SEL_BIT_WIDTH-1:0] REC_SEL_PASS_THROUGH  = 1,
   parameter logic [REC_DATA_SEL_BIT_WIDTH-1:0] REC_SEL_AUTO_TAKE_OFF = 2,
   parameter logic [REC_DATA_SEL_BIT_WIDTH-1:0] REC_SEL_HOVER         = 3,
   parameter logic [REC_DATA_SEL_BIT_WIDTH-1:0] REC_SEL_AUTO_LAND     = 4
) (
   input  logic               us_clk,
   input  logic               reset,
   flight_mode_sel_if.slave   bus
);
   localparam int PW   = PWM_VALUE_BIT_WIDTH;
   localparam int DB_W = $clog2(DEBOUNCE_US + 1);
   localparam int FS_W = $clog2(FAILSAFE_US + 1);

   localparam logic [PW-1:0]   SW_HI     = PW'(SW_HIGH_THRESH);
   localparam logic [PW-1:0]   SW_LO     = PW'(SW_LOW_THRESH);
   localparam logic [PW-1:0]   THR_MAX   = PW'(ARM_THROTTLE_MAX);
   localparam logic [PW-1:0]   HOVER_VAL = PW'(HOVER_THROTTLE_VAL);
   localparam logic [PW-1:0]   MOTOR_LOW = PW'(MOTOR_VAL_MIN + THROTTLE_VARIANCE);
   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_US - 1);
   localparam logic [FS_W-1:0] FS_LAST   = FS_W'(FAILSAFE_US - 1);
   localparam logic [21:0]     TO_LAST   = 22'(TAKEOFF_MAX_US - 1);
   localparam logic [18:0]     LS_LAST   = 19'(LAND_SETTLE_US - 1);

   typedef enum logic [2:0] {
      ST_OFF,
      ST_PASS,
      ST_TAKEOFF,
      ST_HOVER,
      ST_LAND
   } state_t;

   state_t                            state, state_n;
   logic [REC_DATA_SEL_BIT_WIDTH-1:0] sel_q;
   logic                              mode_changed_q;
   logic                              failsafe_q;
   logic [FS_W-1:0]                   fs_cnt;
   logic                              armed_raw, auto_raw;
   logic                              armed_dec, auto_dec;
   logic                              armed_db, auto_db;
   logic [DB_W-1:0]                   arm_cnt, auto_cnt;
   logic [21:0]                       to_cnt;
   logic [18:0]                       settle_cnt;
   logic                              motor_low;

   // Dead band between the thresholds keeps the last registered decode.
   always_comb begin
      armed_dec = armed_raw;
      auto_dec  = auto_raw;
      if (bus.swa_val >= SW_HI)
         armed_dec = 1'b1;
      else if (bus.swa_val <= SW_LO)
         armed_dec = 1'b0;
      if (bus.swb_val >= SW_HI)
         auto_dec = 1'b1;
      else if (bus.swb_val <= SW_LO)
         auto_dec = 1'b0;
   end

   always_ff @(posedge us_clk) begin
      if (reset) begin
         fs_cnt     <= '0;
         failsafe_q <= 1'b0;
         armed_raw  <= 1'b0;
         auto_raw   <= 1'b0;
         armed_db   <= 1'b0;
         auto_db    <= 1'b0;
         arm_cnt    <= '0;
         auto_cnt   <= '0;
      end else begin
         if (bus.rx_valid) begin
            fs_cnt     <= '0;
            failsafe_q <= 1'b0;
         end else if (fs_cnt != FS_LAST) begin
            fs_cnt <= fs_cnt + 1'b1;
         end else begin
            failsafe_q <= 1'b1;
         end

         // Switch reads are meaningless without a link, so freeze them.
         if (!failsafe_q) begin
            armed_raw <= armed_dec;
            auto_raw  <= auto_dec;

            if (armed_dec == armed_db) begin
               arm_cnt <= '0;
            end else if (arm_cnt == DB_LAST) begin
               armed_db <= armed_dec;
               arm_cnt  <= '0;
            end else begin
               arm_cnt <= arm_cnt + 1'b1;
            end

            if (auto_dec == auto_db) begin
               auto_cnt <= '0;
            end else if (auto_cnt == DB_LAST) begin
               auto_db  <= auto_dec;
               auto_cnt <= '0;
            end else begin
               auto_cnt <= auto_cnt + 1'b1;
            end
         end
      end
   end

   assign motor_low = (bus.curr_motor_rate <= MOTOR_LOW);

   always_comb begin
      state_n = state;
      case (state)
         ST_OFF: begin
            if (armed_db && !auto_db && (bus.throttle_rec_val <= THR_MAX) && !failsafe_q)
               state_n = ST_PASS;
            else if (armed_db && auto_db && !failsafe_q)
               state_n = ST_TAKEOFF;
         end
         ST_PASS: begin
            if (!armed_db)
               state_n = ST_OFF;
            else if (failsafe_q)
               state_n = ST_LAND;
            else if (auto_db)
               state_n = ST_HOVER;
         end
         ST_TAKEOFF: begin
            if (failsafe_q || !armed_db)
               state_n = ST_LAND;
            else if (!auto_db)
               state_n = ST_PASS;
            else if ((bus.curr_motor_rate >= HOVER_VAL) || (to_cnt == TO_LAST))
               state_n = ST_HOVER;
         end
         ST_HOVER: begin
            if (failsafe_q || !armed_db)
               state_n = ST_LAND;
            else if (!auto_db)
               state_n = ST_PASS;
         end
         ST_LAND: begin
            if (armed_db && !auto_db && !failsafe_q)
               state_n = ST_PASS;
            else if (settle_cnt == LS_LAST)
               state_n = ST_OFF;
         end
         default: state_n = ST_OFF;
      endcase
   end

   function automatic logic [REC_DATA_SEL_BIT_WIDTH-1:0] sel_of(input state_t s);
      case (s)
         ST_PASS:    return REC_SEL_PASS_THROUGH;
         ST_TAKEOFF: return REC_SEL_AUTO_TAKE_OFF;
         ST_HOVER:   return REC_SEL_HOVER;
         ST_LAND:    return REC_SEL_AUTO_LAND;
         default:    return REC_SEL_OFF;
      endcase
   endfunction

   always_ff @(posedge us_clk) begin
      if (reset) begin
         state          <= ST_OFF;
         sel_q          <= REC_SEL_OFF;
         mode_changed_q <= 1'b0;
         to_cnt         <= '0;
         settle_cnt     <= '0;
      end else begin
         state          <= state_n;
         sel_q          <= sel_of(state_n);
         mode_changed_q <= (sel_of(state_n) != sel_q);
         if (state_n != state) begin
            to_cnt     <= '0;
            settle_cnt <= '0;
         end else begin
            if ((state == ST_TAKEOFF) && (to_cnt != TO_LAST))
               to_cnt <= to_cnt + 1'b1;
            if (!motor_low)
               settle_cnt <= '0;
            else if (settle_cnt != LS_LAST)
               settle_cnt <= settle_cnt + 1'b1;
         end
      end
   end

   assign bus.rec_data_sel = sel_q;
   assign bus.mode_changed = mode_changed_q;
   assign bus.failsafe     = failsafe_q;
endmodule

// File: tb/tb_flight_mode_sel.sv
// tb/tb_flight_mode_sel.sv - directed bench for flight_mode_sel
module tb_flight_mode_sel;
   localparam logic [2:0] OFF  = 3'd0;
   localparam logic [2:0] PASS = 3'd1;
   localparam logic [2:0] TKO  = 3'd2;
   localparam logic [2:0] HOV  = 3'd3;
   localparam logic [2:0] LAND = 3'd4;

   logic us_clk = 1'b0;
   logic reset  = 1'b1;
   int   total  = 0;
   int   passed = 0;

   flight_mode_sel_if #(.PWM_VALUE_BIT_WIDTH(8), .REC_DATA_SEL_BIT_WIDTH(3)) bus ();

   flight_mode_sel #(
      .DEBOUNCE_US(4),
      .FAILSAFE_US(8),
      .TAKEOFF_MAX_US(50),
      .LAND_SETTLE_US(6)
   ) dut (
      .us_clk(us_clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 us_clk = ~us_clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge us_clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic chk_sel(input string tag, input logic [2:0] exp);
      chk(tag, 32'(bus.rec_data_sel), 32'(exp));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.swa_val          = 8'd0;
      bus.swb_val          = 8'd0;
      bus.throttle_rec_val = 8'd0;
      bus.curr_motor_rate  = 8'd0;
      bus.rx_valid         = 1'b1;
      tick(3);
      chk_sel("reset_sel", OFF);
      chk("reset_mc", 32'(bus.mode_changed), 0);
      chk("reset_fs", 32'(bus.failsafe), 0);

      // Arm into pass-through: 5 edges, one pulse.
      reset = 1'b0;
      bus.swa_val = 8'd200;
      bus.swb_val = 8'd50;
      bus.throttle_rec_val = 8'd5;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk_sel("arm_wait_sel", OFF);
         chk("arm_wait_mc", 32'(bus.mode_changed), 0);
      end
      tick(1);
      chk_sel("arm_pass", PASS);
      chk("arm_pass_mc", 32'(bus.mode_changed), 1);
      tick(1);
      chk_sel("arm_pass_hold", PASS);
      chk("arm_pass_mc_clear", 32'(bus.mode_changed), 0);
      bus.swa_val = 8'd50;
      tick(5);
      chk_sel("disarm_off", OFF);

      // High throttle blocks arming until lowered.
      bus.throttle_rec_val = 8'd120;
      bus.swa_val = 8'd200;
      tick(8);
      chk_sel("thr_high_off", OFF);
      bus.throttle_rec_val = 8'd5;
      tick(1);
      chk_sel("thr_low_pass", PASS);
      chk("thr_low_mc", 32'(bus.mode_changed), 1);

      // Glitch shorter than the debounce window and dead band.
      bus.swa_val = 8'd50;
      tick(3);
      bus.swa_val = 8'd200;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         chk_sel("glitch_sel", PASS);
         chk("glitch_mc", 32'(bus.mode_changed), 0);
      end
      bus.swa_val = 8'd125;
      tick(8);
      chk_sel("deadband_pass", PASS);
      bus.swa_val = 8'd50;
      tick(5);
      chk_sel("deadband_exit_off", OFF);

      // Auto takeoff, motor rate reaching hover.
      bus.swb_val = 8'd200;
      tick(4);
      chk_sel("auto_disarmed_off", OFF);
      bus.swa_val = 8'd200;
      tick(4);
      chk_sel("tko_wait", OFF);
      tick(1);
      chk_sel("tko_enter", TKO);
      chk("tko_enter_mc", 32'(bus.mode_changed), 1);
      bus.curr_motor_rate = 8'd100;
      tick(1);
      chk_sel("tko_motor100", TKO);
      bus.curr_motor_rate = 8'd149;
      tick(1);
      chk_sel("tko_motor149", TKO);
      bus.curr_motor_rate = 8'd150;
      tick(1);
      chk_sel("tko_motor_hover", HOV);
      chk("tko_motor_hover_mc", 32'(bus.mode_changed), 1);

      // Disarm to LAND, settle to OFF.
      bus.curr_motor_rate = 8'd0;
      bus.swa_val = 8'd50;
      tick(4);
      chk_sel("hover_disarm_wait", HOV);
      tick(1);
      chk_sel("hover_disarm_land", LAND);
      tick(5);
      chk_sel("land_settling", LAND);
      tick(1);
      chk_sel("land_settled_off", OFF);

      // Takeoff timer expiry with no motor feedback.
      bus.swa_val = 8'd200;
      tick(5);
      chk_sel("tko2_enter", TKO);
      tick(49);
      chk_sel("tko2_timer_wait", TKO);
      tick(1);
      chk_sel("tko2_timer_hover", HOV);

      // Link loss in hover.
      bus.rx_valid = 1'b0;
      tick(7);
      chk("fs_wait", 32'(bus.failsafe), 0);
      chk_sel("fs_wait_sel", HOV);
      tick(1);
      chk("fs_set", 32'(bus.failsafe), 1);
      chk_sel("fs_set_sel", HOV);
      tick(1);
      chk_sel("fs_land", LAND);
      bus.swa_val = 8'd50;
      tick(5);
      chk_sel("fs_land_settling", LAND);
      bus.swa_val = 8'd200;
      tick(1);
      chk_sel("fs_land_off", OFF);
      bus.rx_valid = 1'b1;
      tick(1);
      chk("fs_clear", 32'(bus.failsafe), 0);
      chk_sel("fs_clear_sel", OFF);
      tick(1);
      chk_sel("fs_armed_kept_tko", TKO);

      // Reset from LAND.
      bus.swa_val = 8'd50;
      tick(5);
      chk_sel("pre_reset_land", LAND);
      tick(2);
      chk_sel("pre_reset_land_hold", LAND);
      reset = 1'b1;
      tick(1);
      chk_sel("midreset_sel", OFF);
      chk("midreset_mc", 32'(bus.mode_changed), 0);
      chk("midreset_fs", 32'(bus.failsafe), 0);
      reset = 1'b0;
      tick(1);
      chk_sel("post_reset_sel", OFF);
      chk("post_reset_mc", 32'(bus.mode_changed), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
